// File: rtl/pipeline_types.sv
// Shared types for the WS2812 decode pipeline: decoder strobes, reshaper
// forwarding, and the pixel capture stage state/outputs.
package pipeline_types;

  typedef struct packed {
    logic valid;
    logic decoded_bit;
    logic treset;
  } shift_reg_t;

  typedef struct packed {
    logic enable;
    logic decoded_bit;
  } reshaper_t;

  typedef enum logic {
    CAPTURE  = 1'b0,
    PASSTHRU = 1'b1
  } capture_state_t;

  localparam int PIXEL_DATA_MAX  = 32;
  localparam int PIXEL_INDEX_MAX = 16;

  // Widest-case view of a captured pixel, for stages that bundle the outputs
  typedef struct packed {
    logic [PIXEL_DATA_MAX-1:0]  data;
    logic [PIXEL_INDEX_MAX-1:0] index;
    logic                       valid;
  } pixel_out_t;

endpackage

// File: rtl/ws2812_pixel_capture.sv
// Captures the first NUM_PIXELS pixels of a WS2812 frame from decoded bits,
// then forwards the remaining bits downstream until the next latch/reset.
module ws2812_pixel_capture
  import pipeline_types::*;
#(
  parameter int  PIXEL_BITS = 24,
  parameter int  NUM_PIXELS = 1,
  localparam int IDX_W      = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  shift_reg_t            i_shift_reg,
  output logic [PIXEL_BITS-1:0] o_pixel_data,
  output logic                  o_pixel_valid,
  output logic [IDX_W-1:0]      o_pixel_index,
  output logic                  o_frame_done,
  output reshaper_t             o_reshaper
);

  if (PIXEL_BITS != 24 && PIXEL_BITS != 32) begin : g_bad_pixel_bits
    $error("ws2812_pixel_capture: PIXEL_BITS must be 24 or 32");
  end
  if (NUM_PIXELS < 1) begin : g_bad_num_pixels
    $error("ws2812_pixel_capture: NUM_PIXELS must be at least 1");
  end

  localparam int                   BIT_W    = $clog2(PIXEL_BITS);
  localparam logic [BIT_W-1:0]     LAST_BIT = BIT_W'(PIXEL_BITS - 1);
  localparam logic [IDX_W-1:0]     LAST_PIX = IDX_W'(NUM_PIXELS - 1);

  capture_state_t        state_reg, state_next;
  logic [BIT_W-1:0]      bit_cnt_reg, bit_cnt_next;
  logic [IDX_W-1:0]      pix_cnt_reg, pix_cnt_next;
  logic [PIXEL_BITS-1:0] shift_data_reg, shift_data_next;
  logic [PIXEL_BITS-1:0] pixel_data_reg, pixel_data_next;
  logic [IDX_W-1:0]      pixel_index_reg, pixel_index_next;
  logic                  pixel_valid_reg, pixel_valid_next;
  logic                  frame_done_reg, frame_done_next;
  logic [PIXEL_BITS-1:0] shift_word;

  // First-received bit ends up at the MSB once the word is full
  assign shift_word = {shift_data_reg[PIXEL_BITS-2:0], i_shift_reg.decoded_bit};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg       <= CAPTURE;
      bit_cnt_reg     <= '0;
      pix_cnt_reg     <= '0;
      shift_data_reg  <= '0;
      pixel_data_reg  <= '0;
      pixel_index_reg <= '0;
      pixel_valid_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      bit_cnt_reg     <= bit_cnt_next;
      pix_cnt_reg     <= pix_cnt_next;
      shift_data_reg  <= shift_data_next;
      pixel_data_reg  <= pixel_data_next;
      pixel_index_reg <= pixel_index_next;
      pixel_valid_reg <= pixel_valid_next;
      frame_done_reg  <= frame_done_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    bit_cnt_next     = bit_cnt_reg;
    pix_cnt_next     = pix_cnt_reg;
    shift_data_next  = shift_data_reg;
    pixel_data_next  = pixel_data_reg;
    pixel_index_next = pixel_index_reg;
    pixel_valid_next = 1'b0;
    frame_done_next  = 1'b0;

    // Latch/reset outranks a coincident bit, including a pixel's final bit
    if (i_shift_reg.treset) begin
      state_next      = CAPTURE;
      bit_cnt_next    = '0;
      pix_cnt_next    = '0;
      shift_data_next = '0;
    end else if (state_reg == CAPTURE && i_shift_reg.valid) begin
      shift_data_next = shift_word;
      if (bit_cnt_reg == LAST_BIT) begin
        bit_cnt_next     = '0;
        pixel_data_next  = shift_word;
        pixel_index_next = pix_cnt_reg;
        pixel_valid_next = 1'b1;
        if (pix_cnt_reg == LAST_PIX) begin
          frame_done_next = 1'b1;
          state_next      = PASSTHRU;
        end else begin
          pix_cnt_next = pix_cnt_reg + IDX_W'(1);
        end
      end else begin
        bit_cnt_next = bit_cnt_reg + BIT_W'(1);
      end
    end
  end

  assign o_pixel_data       = pixel_data_reg;
  assign o_pixel_valid      = pixel_valid_reg;
  assign o_pixel_index      = pixel_index_reg;
  assign o_frame_done       = frame_done_reg;
  assign o_reshaper.enable      = (state_reg == PASSTHRU);
  assign o_reshaper.decoded_bit = i_shift_reg.decoded_bit;

endmodule

// File: tb/tb_ws2812_pixel_capture.sv
// Drives an RGB single-pixel capture and an RGBW three-pixel capture with the
// same decoded-bit stream and scoreboards both against a frame-level model.
module tb_ws2812_pixel_capture;
  import pipeline_types::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  shift_reg_t sr_in;

  logic [23:0] d0_data;
  logic        d0_valid;
  logic [0:0]  d0_idx;
  logic        d0_done;
  reshaper_t   d0_rs;

  logic [31:0] d1_data;
  logic        d1_valid;
  logic [1:0]  d1_idx;
  logic        d1_done;
  reshaper_t   d1_rs;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ws2812_pixel_capture #(.PIXEL_BITS(24), .NUM_PIXELS(1)) u_rgb (
    .i_clk(clk), .i_reset_n(rst_n), .i_shift_reg(sr_in),
    .o_pixel_data(d0_data), .o_pixel_valid(d0_valid), .o_pixel_index(d0_idx),
    .o_frame_done(d0_done), .o_reshaper(d0_rs)
  );

  ws2812_pixel_capture #(.PIXEL_BITS(32), .NUM_PIXELS(3)) u_rgbw (
    .i_clk(clk), .i_reset_n(rst_n), .i_shift_reg(sr_in),
    .o_pixel_data(d1_data), .o_pixel_valid(d1_valid), .o_pixel_index(d1_idx),
    .o_frame_done(d1_done), .o_reshaper(d1_rs)
  );

  // ---------------- reference model (frame level) ----------------
  typedef struct {
    logic [31:0] data;
    int          idx;
    bit          done;
  } exp_t;

  int          pb [2] = '{24, 32};
  int          np [2] = '{1, 3};
  bit          bq [2][$];
  int          pix [2];
  bit          pass [2];
  bit          strobe_now [2];
  logic [31:0] held_data [2];
  int          held_idx [2];
  exp_t        sb [2][$];

  initial begin
    for (int d = 0; d < 2; d++) begin
      pix[d] = 0; pass[d] = 0; strobe_now[d] = 0; held_data[d] = '0; held_idx[d] = 0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      for (int d = 0; d < 2; d++) begin
        strobe_now[d] = 0;
        if (!rst_n) begin
          bq[d].delete(); pix[d] = 0; pass[d] = 0;
          held_data[d] = '0; held_idx[d] = 0; sb[d].delete();
        end else if (sr_in.treset) begin
          bq[d].delete(); pix[d] = 0; pass[d] = 0;
        end else if (sr_in.valid && !pass[d]) begin
          bq[d].push_back(sr_in.decoded_bit);
          if (bq[d].size() == pb[d]) begin
            exp_t e;
            e.data = '0;
            foreach (bq[d][i]) e.data = (e.data << 1) | 32'(bq[d][i]);
            e.idx  = pix[d];
            e.done = (pix[d] == np[d] - 1);
            sb[d].push_back(e);
            strobe_now[d] = 1;
            held_data[d]  = e.data;
            held_idx[d]   = e.idx;
            bq[d].delete();
            if (e.done) pass[d] = 1;
            else pix[d]++;
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic check_dut(input int d, input logic [31:0] data, input int idx,
                           input logic v, input logic dn, input reshaper_t rs);
    pixel_out_t obs;
    string      p;
    p = $sformatf("dut%0d", d);
    obs.data  = data;
    obs.index = 16'(idx);
    obs.valid = v;
    chk({p, " enable"}, 32'(rs.enable), 32'(pass[d]));
    chk({p, " fwd_bit"}, 32'(rs.decoded_bit), 32'(sr_in.decoded_bit));
    chk({p, " pixel_valid"}, 32'(obs.valid), 32'(strobe_now[d]));
    if (obs.valid) begin
      n_vec++;
      if (sb[d].size() == 0) begin
        n_err++;
        $display("FAIL %s scoreboard: got strobe data %h expected no strobe", p, obs.data);
      end else begin
        exp_t e;
        e = sb[d].pop_front();
        chk({p, " data"}, obs.data, e.data);
        chk({p, " index"}, 32'(obs.index), 32'(e.idx));
        chk({p, " frame_done"}, 32'(dn), 32'(e.done));
        $display("%s pixel idx=%0d data=%h frame_done=%0b", p, obs.index, obs.data, dn);
      end
    end else begin
      chk({p, " frame_done_idle"}, 32'(dn), 32'(1'b0));
    end
    chk({p, " held_data"}, obs.data, held_data[d]);
    chk({p, " held_index"}, 32'(obs.index), 32'(held_idx[d]));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check_dut(0, 32'(d0_data), int'(d0_idx), d0_valid, d0_done, d0_rs);
      check_dut(1, d1_data, int'(d1_idx), d1_valid, d1_done, d1_rs);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input bit b, input bit t);
    @(posedge clk);
    #2;
    sr_in.valid       = v;
    sr_in.decoded_bit = b;
    sr_in.treset      = t;
  endtask

  task automatic send_word(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) drive(1'b1, w[i], 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sr_in = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // single RGB pixel frame
    send_word(32'h00A5C3F0, 24);
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("dir rgb data", 32'(d0_data), 32'h00A5C3F0);
    chk("dir rgb valid", 32'(d0_valid), 32'd1);
    chk("dir rgb done", 32'(d0_done), 32'd1);
    chk("dir rgb index", 32'(d0_idx), 32'd0);
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("dir rgb enable", 32'(d0_rs.enable), 32'd1);

    // three RGBW pixels then passthrough bits
    drive(1'b0, 1'b0, 1'b1);
    send_word(32'h11223344, 32);
    send_word(32'h55667788, 32);
    send_word(32'h99AABBCC, 32);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    @(negedge clk);
    chk("dir rgbw held data", d1_data, 32'h99AABBCC);
    chk("dir rgbw enable", 32'(d1_rs.enable), 32'd1);

    // partial pixel discarded by treset
    drive(1'b0, 1'b0, 1'b1);
    send_word(32'h00001ABC, 13);
    drive(1'b0, 1'b0, 1'b1);
    send_word(32'h00000001, 24);
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("dir partial data", 32'(d0_data), 32'h00000001);
    chk("dir partial valid", 32'(d0_valid), 32'd1);

    // treset with valid while passing through
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("dir treset enable", 32'(d0_rs.enable), 32'd0);

    // asynchronous reset mid-pixel
    send_word(32'h0001ABCD, 17);
    @(posedge clk);
    #4 rst_n = 1'b0;
    sr_in = '0;
    #1;
    chk("async rgb data", 32'(d0_data), 32'd0);
    chk("async rgb valid", 32'(d0_valid), 32'd0);
    chk("async rgb index", 32'(d0_idx), 32'd0);
    chk("async rgb done", 32'(d0_done), 32'd0);
    chk("async rgbw data", d1_data, 32'd0);
    chk("async rgbw enable", 32'(d1_rs.enable), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    send_word(32'h00C0FFEE, 24);
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("post reset data", 32'(d0_data), 32'h00C0FFEE);

    // randomized stream
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 199) == 0));
    end
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rgb scoreboard empty", 32'(sb[0].size()), 32'd0);
    chk("rgbw scoreboard empty", 32'(sb[1].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
